// File: rtl/cnv_pkg.sv
// cnv_pkg: shared definitions for the convolution row unit.
//   - prod_w / acc_w : width derivations for products and the chained sum
//   - sat_clip       : clamps a signed value into a w-bit signed range
//   - ST_*           : FSM state encodings for cnv_row_gen
package cnv_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    // Wide enough that summing every product of every stage cannot overflow.
    function automatic int acc_w(input int data_w, input int depth, input int kh);
        return 2 * data_w + $clog2(depth * kh);
    endfunction

    // Operates on 64-bit carriers so one function serves any PSUM_W up to 63.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                    input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/cnv_mac_stage.sv
// cnv_mac_stage: one sparse multiply-accumulate stage (one kernel row).
//   clk, rst_n : clock, async active-low reset
//   load       : capture masks/weights and start a new block
//   flg_act    : activation nonzero mask (raw, sampled on load)
//   flg_wei    : this stage's weight nonzero mask (sampled on load)
//   wei        : this stage's weight block (sampled on load)
//   act        : activation block, held stable by the parent while busy
//   busy       : stage is walking its mask
//   fnh        : one-cycle pulse when the walk has finished
//   acc        : masked dot product, held after finishing
module cnv_mac_stage
    import cnv_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int BLOCK_DEPTH = 32,
    parameter int ACC_W       = 23
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [BLOCK_DEPTH-1:0]        flg_act,
    input  logic [BLOCK_DEPTH-1:0]        flg_wei,
    input  logic [DATA_W*BLOCK_DEPTH-1:0] wei,
    input  logic [DATA_W*BLOCK_DEPTH-1:0] act,
    output logic                          busy,
    output logic                          fnh,
    output logic [ACC_W-1:0]              acc
);

    localparam int IDX_W  = $clog2(BLOCK_DEPTH);
    localparam int PROD_W = prod_w(DATA_W);

    logic [BLOCK_DEPTH-1:0]        mask;
    logic [DATA_W*BLOCK_DEPTH-1:0] wei_q;
    logic [IDX_W-1:0]              idx;
    logic signed [DATA_W-1:0]      a_e;
    logic signed [DATA_W-1:0]      w_e;
    logic signed [PROD_W-1:0]      prod;

    // Lowest set bit wins: scan high to low so the last hit is the lowest.
    always_comb begin
        idx = '0;
        for (int i = BLOCK_DEPTH - 1; i >= 0; i--)
            if (mask[i]) idx = IDX_W'(i);
    end

    assign a_e  = act[idx*DATA_W +: DATA_W];
    assign w_e  = wei_q[idx*DATA_W +: DATA_W];
    assign prod = PROD_W'(a_e) * PROD_W'(w_e);

    // Finish is seen in the cycle the mask runs empty, so an empty mask
    // finishes in the first cycle after load.
    assign fnh = busy && (mask == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask  <= '0;
            wei_q <= '0;
            acc   <= '0;
            busy  <= 1'b0;
        end else if (load) begin
            mask  <= flg_act & flg_wei;
            wei_q <= wei;
            acc   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            if (mask == '0) begin
                busy <= 1'b0;
            end else begin
                acc  <= acc + ACC_W'(prod);
                mask <= mask & (mask - BLOCK_DEPTH'(1));  // drop lowest set bit
            end
        end
    end

endmodule

// File: rtl/cnv_row_gen.sv
// cnv_row_gen: convolution row unit. KH sparse MAC stages share one
// activation block; their chained sum is committed, with optional psum_in
// and saturation, into a LEN_ROW-deep partial-sum shift row.
//   clk, rst_n        : clock, async active-low reset
//   sta               : start a block MAC (accepted in IDLE only)
//   flg_act, act      : activation mask / block
//   flg_wei, wei      : per-stage weight masks / blocks
//   stg_fnh           : per-stage finish pulse
//   mac_done          : chained result ready, awaiting pls_acc
//   pls_acc, acc_en   : commit strobe, add psum_in when acc_en
//   psum_in           : upstream partial sum
//   fnh_row           : row complete, restart position count
//   psum_out          : row tail entry
//   row_vld           : LEN_ROW commits since last fnh_row/reset
//   sat_flg, err_flg  : sticky saturation / protocol-error flags
module cnv_row_gen
    import cnv_pkg::*;
#(
    parameter int KH          = 3,
    parameter int LEN_ROW     = 14,
    parameter int DATA_W      = 8,
    parameter int BLOCK_DEPTH = 32,
    parameter int PSUM_W      = 24
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sta,
    input  logic [BLOCK_DEPTH-1:0]           flg_act,
    input  logic [DATA_W*BLOCK_DEPTH-1:0]    act,
    input  logic [KH*BLOCK_DEPTH-1:0]        flg_wei,
    input  logic [KH*DATA_W*BLOCK_DEPTH-1:0] wei,
    output logic [KH-1:0]                    stg_fnh,
    output logic                             mac_done,
    input  logic                             pls_acc,
    input  logic                             acc_en,
    input  logic [PSUM_W-1:0]                psum_in,
    input  logic                             fnh_row,
    output logic [PSUM_W-1:0]                psum_out,
    output logic                             row_vld,
    output logic                             sat_flg,
    output logic                             err_flg
);

    localparam int ACC_W = acc_w(DATA_W, BLOCK_DEPTH, KH);
    localparam int POS_W = $clog2(LEN_ROW + 1);
    localparam int BLK_W = DATA_W * BLOCK_DEPTH;

    logic [1:0]                      state;
    logic [BLK_W-1:0]                act_q;
    logic [KH-1:0]                   stg_busy;
    logic [KH-1:0][ACC_W-1:0]        stg_acc;
    logic signed [ACC_W-1:0]         chain;
    logic signed [PSUM_W:0]          sum_w;
    logic signed [63:0]              sum64;
    logic signed [63:0]              clip;
    logic [PSUM_W-1:0]               sum_sat;
    logic                            sat_hit;
    logic [LEN_ROW-1:0][PSUM_W-1:0]  row_q;
    logic [POS_W-1:0]                pos_cnt;
    logic                            start;
    logic                            commit;
    logic                            all_done;

    assign start    = sta && (state == ST_IDLE);
    assign commit   = pls_acc && (state == ST_DONE);
    assign all_done = &(stg_fnh | ~stg_busy);
    assign mac_done = (state == ST_DONE);

    for (genvar k = 0; k < KH; k++) begin : g_stage
        cnv_mac_stage #(
            .DATA_W      (DATA_W),
            .BLOCK_DEPTH (BLOCK_DEPTH),
            .ACC_W       (ACC_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (start),
            .flg_act (flg_act),
            .flg_wei (flg_wei[k*BLOCK_DEPTH +: BLOCK_DEPTH]),
            .wei     (wei[k*BLK_W +: BLK_W]),
            .act     (act_q),
            .busy    (stg_busy[k]),
            .fnh     (stg_fnh[k]),
            .acc     (stg_acc[k])
        );
    end

    // ACC_W is sized for the whole chain, so plain wrap-around adds are exact.
    always_comb begin
        chain = '0;
        for (int k = 0; k < KH; k++)
            chain = chain + $signed(stg_acc[k]);
    end

    // One extra bit holds any PSUM_W + ACC_W sum; clamp afterwards.
    assign sum_w   = (PSUM_W+1)'(chain)
                   + (acc_en ? (PSUM_W+1)'(signed'(psum_in)) : '0);
    assign sum64   = 64'(sum_w);
    assign clip    = sat_clip(sum64, PSUM_W);
    assign sum_sat = clip[PSUM_W-1:0];
    assign sat_hit = (clip != sum64);

    assign psum_out = row_q[LEN_ROW-1];
    assign row_vld  = (pos_cnt == POS_W'(LEN_ROW));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            act_q <= '0;
        end else begin
            if (start) act_q <= act;
            case (state)
                ST_IDLE: if (sta)      state <= ST_RUN;
                ST_RUN:  if (all_done) state <= ST_DONE;
                ST_DONE: if (pls_acc)  state <= ST_IDLE;
                default:               state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            pos_cnt <= '0;
            sat_flg <= 1'b0;
            err_flg <= 1'b0;
        end else begin
            if (commit) begin
                row_q <= {row_q[LEN_ROW-2:0], sum_sat};
                if (fnh_row)
                    pos_cnt <= POS_W'(1);  // this commit opens the new row
                else if (!row_vld)
                    pos_cnt <= pos_cnt + POS_W'(1);
            end else if (fnh_row) begin
                pos_cnt <= '0;
            end
            // A saturating commit alongside fnh_row belongs to the new row.
            if (commit && sat_hit)
                sat_flg <= 1'b1;
            else if (fnh_row)
                sat_flg <= 1'b0;
            if ((pls_acc && state != ST_DONE) || (sta && state != ST_IDLE))
                err_flg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cnv_row_gen.sv
// tb_cnv_row_gen: directed self-checking bench for cnv_row_gen
// (KH=3, LEN_ROW=14, DATA_W=8, BLOCK_DEPTH=32, PSUM_W=24).
module tb_cnv_row_gen;

    localparam int KH          = 3;
    localparam int LEN_ROW     = 14;
    localparam int DATA_W      = 8;
    localparam int BLOCK_DEPTH = 32;
    localparam int PSUM_W      = 24;

    logic                             clk;
    logic                             rst_n;
    logic                             sta;
    logic [BLOCK_DEPTH-1:0]           flg_act;
    logic [DATA_W*BLOCK_DEPTH-1:0]    act;
    logic [KH*BLOCK_DEPTH-1:0]        flg_wei;
    logic [KH*DATA_W*BLOCK_DEPTH-1:0] wei;
    logic [KH-1:0]                    stg_fnh;
    logic                             mac_done;
    logic                             pls_acc;
    logic                             acc_en;
    logic [PSUM_W-1:0]                psum_in;
    logic                             fnh_row;
    logic [PSUM_W-1:0]                psum_out;
    logic                             row_vld;
    logic                             sat_flg;
    logic                             err_flg;

    int n_cmp = 0;
    int n_bad = 0;

    cnv_row_gen #(
        .KH(KH), .LEN_ROW(LEN_ROW), .DATA_W(DATA_W),
        .BLOCK_DEPTH(BLOCK_DEPTH), .PSUM_W(PSUM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sta(sta),
        .flg_act(flg_act), .act(act), .flg_wei(flg_wei), .wei(wei),
        .stg_fnh(stg_fnh), .mac_done(mac_done),
        .pls_acc(pls_acc), .acc_en(acc_en), .psum_in(psum_in),
        .fnh_row(fnh_row), .psum_out(psum_out), .row_vld(row_vld),
        .sat_flg(sat_flg), .err_flg(err_flg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        flg_act = '0; act = '0; flg_wei = '0; wei = '0;
    endtask

    // Stage 0 computes 1*v on element 0; stages 1-2 have empty masks.
    task automatic set_simple(input logic [7:0] v);
        clr_in();
        flg_act[0] = 1'b1;
        act[7:0]   = 8'd1;
        flg_wei[0] = 1'b1;
        wei[7:0]   = v;
    endtask

    task automatic set_full();
        flg_act = '1; flg_wei = '1;
        act = {BLOCK_DEPTH{8'h01}};
        wei = {KH*BLOCK_DEPTH{8'h02}};
    endtask

    task automatic set_sparse();
        clr_in();
        flg_act          = 32'h5;
        act[2*8 +: 8]    = 8'hFD;   // -3
        flg_wei[31:0]    = 32'h4;
        wei[2*8 +: 8]    = 8'h07;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!mac_done && n < 200) begin
            step();
            n++;
        end
        chk("mac_done_wait", 64'(mac_done), 64'd1);
    endtask

    task automatic run_mac();
        sta = 1'b1;
        step();
        sta = 1'b0;
        wait_done();
    endtask

    task automatic commit(input logic ae, input logic [PSUM_W-1:0] pin, input logic fr);
        pls_acc = 1'b1; acc_en = ae; psum_in = pin; fnh_row = fr;
        step();
        pls_acc = 1'b0; acc_en = 1'b0; psum_in = '0; fnh_row = 1'b0;
    endtask

    task automatic push(input logic [7:0] v);
        set_simple(v);
        run_mac();
        commit(1'b0, '0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; sta = 1'b0; pls_acc = 1'b0; acc_en = 1'b0;
        psum_in = '0; fnh_row = 1'b0;
        clr_in();
        step(); step();
        chk("rst_psum_out", 64'(psum_out), 64'd0);
        chk("rst_row_vld",  64'(row_vld),  64'd0);
        chk("rst_flags",    64'({sat_flg, err_flg, mac_done}), 64'd0);
        chk("rst_stg_fnh",  64'(stg_fnh),  64'd0);
        rst_n = 1'b1;
        step();

        // c1: dense block, each stage 32*1*2 = 64, chain 192.
        set_full();
        sta = 1'b1;
        step();                                 // t+1
        sta = 1'b0;
        for (int i = 0; i < 31; i++) step();    // t+32
        chk("dense_fnh_t32", 64'(stg_fnh), 64'd0);
        step();                                 // t+33
        chk("dense_fnh_t33", 64'(stg_fnh), 64'b111);
        chk("dense_done_t33", 64'(mac_done), 64'd0);
        step();                                 // t+34
        chk("dense_done_t34", 64'(mac_done), 64'd1);
        chk("dense_fnh_t34", 64'(stg_fnh), 64'd0);
        commit(1'b0, 24'h123456, 1'b0);         // acc_en=0 ignores psum_in
        chk("dense_done_fall", 64'(mac_done), 64'd0);

        // c2: sparse block, -3*7 + 10 = -11.
        set_sparse();
        sta = 1'b1;
        step();                                 // t+1
        sta = 1'b0;
        chk("sparse_fnh_t1", 64'(stg_fnh), 64'b110);
        step();
        chk("sparse_fnh_t2", 64'(stg_fnh), 64'b001);
        step();
        chk("sparse_done_t3", 64'(mac_done), 64'd1);
        commit(1'b1, 24'd10, 1'b0);

        // c3..c13
        for (int v = 3; v <= 13; v++) push(8'(v));
        chk("row_vld_13", 64'(row_vld), 64'd0);
        push(8'd14);                            // c14
        chk("row_vld_14", 64'(row_vld), 64'd1);
        chk("tail_c1", 64'(psum_out), 64'h0000C0);
        push(8'd99);                            // c15
        chk("tail_c2", 64'(psum_out), 64'hFFFFF5);
        chk("row_vld_15", 64'(row_vld), 64'd1);

        fnh_row = 1'b1;
        step();
        fnh_row = 1'b0;
        chk("fnh_row_vld", 64'(row_vld), 64'd0);
        chk("fnh_row_keep", 64'(psum_out), 64'hFFFFF5);

        // c16 with fnh_row: position count restarts at 1.
        set_simple(8'd5);
        run_mac();
        commit(1'b0, '0, 1'b1);
        chk("tail_c3", 64'(psum_out), 64'd3);
        for (int v = 20; v <= 31; v++) push(8'(v));  // c17..c28
        chk("row_vld_pos13", 64'(row_vld), 64'd0);
        push(8'd40);                                 // c29
        chk("row_vld_pos14", 64'(row_vld), 64'd1);
        chk("tail_c16", 64'(psum_out), 64'd5);

        // c30: +5 + (2^23-1) clamps high; c31: -5 + -2^23 clamps low.
        chk("sat_pre", 64'(sat_flg), 64'd0);
        set_simple(8'd5);
        run_mac();
        commit(1'b1, 24'h7FFFFF, 1'b0);
        chk("sat_pos_flag", 64'(sat_flg), 64'd1);
        set_simple(8'hFB);
        run_mac();
        commit(1'b1, 24'h800000, 1'b0);
        for (int v = 1; v <= 12; v++) push(8'(v));   // c32..c43
        chk("sat_pos_val", 64'(psum_out), 64'h7FFFFF);
        push(8'd0);                                  // c44
        chk("sat_neg_val", 64'(psum_out), 64'h800000);
        chk("sat_sticky", 64'(sat_flg), 64'd1);
        fnh_row = 1'b1;
        step();
        fnh_row = 1'b0;
        chk("sat_clear", 64'(sat_flg), 64'd0);
        push(8'd0);                                  // c45
        chk("sat_stay_clear", 64'(sat_flg), 64'd0);
        chk("tail_c32", 64'(psum_out), 64'd1);
        chk("err_pre", 64'(err_flg), 64'd0);

        // Protocol errors.
        clr_in();
        flg_act = '1; flg_wei[31:0] = '1;
        act = {BLOCK_DEPTH{8'h01}};
        wei[BLOCK_DEPTH*DATA_W-1:0] = {BLOCK_DEPTH{8'h02}};
        sta = 1'b1;
        step();
        sta = 1'b0;
        pls_acc = 1'b1;                         // during RUN
        step();
        pls_acc = 1'b0;
        chk("err_pls_run", 64'(err_flg), 64'd1);
        chk("err_pls_noshift", 64'(psum_out), 64'd1);
        chk("err_pls_nodone", 64'(mac_done), 64'd0);
        wait_done();
        sta = 1'b1;                             // during DONE
        step();
        sta = 1'b0;
        chk("err_sta_done", 64'(mac_done), 64'd1);
        chk("err_sta_noshift", 64'(psum_out), 64'd1);
        pls_acc = 1'b1; sta = 1'b1;             // commit wins, sta ignored
        step();
        pls_acc = 1'b0; sta = 1'b0;
        chk("both_done_fall", 64'(mac_done), 64'd0);
        chk("both_shift", 64'(psum_out), 64'd2);
        chk("both_no_start", 64'(stg_fnh), 64'd0);
        step();
        chk("both_idle", 64'(mac_done), 64'd0);

        // Reset mid-RUN.
        set_full();
        sta = 1'b1;
        step();
        sta = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        chk("arst_psum", 64'(psum_out), 64'd0);
        chk("arst_flags", 64'({row_vld, sat_flg, err_flg, mac_done}), 64'd0);
        chk("arst_fnh", 64'(stg_fnh), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        set_sparse();
        sta = 1'b1;
        step();
        sta = 1'b0;
        chk("post_rst_fnh_t1", 64'(stg_fnh), 64'b110);
        step();
        chk("post_rst_fnh_t2", 64'(stg_fnh), 64'b001);
        step();
        chk("post_rst_done", 64'(mac_done), 64'd1);
        commit(1'b1, 24'd10, 1'b0);
        chk("post_rst_fall", 64'(mac_done), 64'd0);
        chk("post_rst_err", 64'(err_flg), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cnv_row_gen.md
# cnv_row_gen

Parametrised convolution row unit for the PE array. Chains KH sparse multiply-accumulate stages, one per kernel row, sharing one activation block. It adds the chained result to an incoming partial sum, with optional bypass and saturation, and keeps a LEN_ROW-deep partial-sum shift row. It sits between the PE controller (start, accumulate and row-finish strobes) and the next row unit or the psum writeback, which are fed from the row tail.

## Interface
- KH, 3: number of kernel rows, i.e. chained MAC stages (1..7).
- LEN_ROW, 14: output positions held in the psum row (≥2).
- DATA_W, 8: signed activation/weight width.
- BLOCK_DEPTH, 32: elements per activation/weight block.
- PSUM_W, 24: signed partial-sum width; must be ≥ ACC_W.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sta  in  1  start one block MAC on all stages; accepted only when idle.
- flg_act  in  BLOCK_DEPTH  activation nonzero mask.
- act  in  DATA_W*BLOCK_DEPTH  activation block; element i at [i*DATA_W +: DATA_W].
- flg_wei  in  KH*BLOCK_DEPTH  per-stage weight masks; stage k at [k*BLOCK_DEPTH +: BLOCK_DEPTH].
- wei  in  KH*DATA_W*BLOCK_DEPTH  per-stage weight blocks.
- stg_fnh  out  KH  per-stage one-cycle finish pulse.
- mac_done  out  1  level; all stages finished and result not yet consumed.
- pls_acc  in  1  commit the chained result into the row.
- acc_en  in  1  sampled with pls_acc: 1 adds psum_in, 0 adds zero.
- psum_in  in  PSUM_W  upstream partial sum.
- fnh_row  in  1  row complete; clears the position counter.
- psum_out  out  PSUM_W  tail entry of the row (entry LEN_ROW-1), registered.
- row_vld  out  1  level; LEN_ROW commits since the last fnh_row or reset.
- sat_flg  out  1  sticky; a commit saturated. Cleared by fnh_row.
- err_flg  out  1  sticky; pls_acc arrived without mac_done, or sta arrived while busy. Cleared by reset only.

## Operation
- Stage k computes a masked dot product: S_k = Σ act[i]*wei_k[i] over i where flg_act[i] & flg_wei_k[i]. Products are signed, 2*DATA_W wide.
- Each stage walks set bits of its AND mask lowest-index first, one per cycle, using a priority encoder and clearing the used bit.
- Chain: C = S_0 + … + S_{KH-1}. Width ACC_W = 2*DATA_W + clog2(BLOCK_DEPTH*KH). Sign-extension is exact; no overflow is possible.
- FSM: IDLE -sta-> RUN (every stage busy). RUN -> DONE when every stage has finished; a finished stage holds its result. DONE -pls_acc-> IDLE.
- mac_done = (state==DONE).
- Commit on pls_acc in DONE:
  - sum = sext(C) + (acc_en ? psum_in : 0), computed at PSUM_W+1 bits.
  - The sum saturates to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1]; on saturation, sat_flg is set.
  - Row shifts: entry0 <= sum, entry j <= entry j-1.
  - pos_cnt increments, saturating at LEN_ROW. row_vld = (pos_cnt==LEN_ROW).
- pls_acc outside DONE: no shift, no state change, err_flg set.
- sta outside IDLE: ignored, err_flg set.
- fnh_row: pos_cnt <= 0 and sat_flg <= 0. Row contents are retained and are overwritten by later shifts.
- Simultaneous fnh_row and a valid pls_acc: the shift happens and pos_cnt <= 1.
- Simultaneous pls_acc in DONE and sta: the commit happens; sta is ignored and flagged.

## Timing
- Reset: all row entries, psum_out, pos_cnt, stg_fnh, mac_done, row_vld, sat_flg and err_flg are 0; FSM is IDLE.
- sta at cycle t: the stages load at t+1.
- A stage with n set AND bits pulses stg_fnh at t+1+n. An empty mask pulses at t+1.
- mac_done rises the cycle after the last stg_fnh.
- pls_acc at cycle u: row and psum_out update at u+1; mac_done falls at u+1.
- The earliest next sta is at u+1.
- Asserting rst_n low mid-RUN aborts the operation and takes effect immediately.

## Structure
- Package cnv_pkg holds ACC_W and PROD_W derivation functions, the saturation function and the FSM state enum.
- Sub-module cnv_mac_stage: one sparse stage with a bit-walk counter, priority encoder, accumulator and finish pulse. It is instantiated KH times by a generate loop.
- The top holds the FSM, chain adder, saturating commit, row shift register and flags.

## Test plan
- KH=3, all masks 0xFFFFFFFF, act=1, wei=2, acc_en=0, pls_acc -> each stg_fnh at t+33; psum_out after LEN_ROW commits = 192.
- flg_act=0x5, flg_wei_0=0x4, others 0, act[2]=-3, wei_0[2]=7, acc_en=1, psum_in=10 -> stg_fnh[0] at t+2, stg_fnh[1:2] at t+1, committed value -11.
- 14 commits of values 1..14 -> row_vld high after the 14th; psum_out=1. fnh_row -> row_vld=0; the next commit shifts, pos_cnt=1.
- psum_in=2^23-1, C=+5, acc_en=1 -> psum entry 0x7FFFFF, sat_flg=1. Then fnh_row -> sat_flg=0.
- pls_acc during RUN, and sta during DONE -> no shift, err_flg=1, FSM unchanged.
- rst_n pulsed low mid-RUN -> all outputs 0 and IDLE; a fresh sta completes normally.
